// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// the responder state type, and helpers for fault checking and lane steering.
package riscv_pkg;

    // funct3 access codes (stores reuse LB/LH/LW)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Misaligned halves/words, reserved codes, and unsigned "stores" are rejected.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] off,
                                          input logic is_wr);
        logic flt;
        flt = 1'b0;
        case (f3)
            F3_LB:   flt = 1'b0;
            F3_LH:   flt = off[0];
            F3_LW:   flt = (off != 2'b00);
            F3_LBU:  flt = is_wr;
            F3_LHU:  flt = is_wr | off[0];
            default: flt = 1'b1;
        endcase
        return flt;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_LB:   be = 4'b0001 << off;
            F3_LH:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the low bytes so whichever lanes are enabled see the right data.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_LB:   d = {4{wd[7:0]}};
            F3_LH:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LBU:  r = {24'h0, b};
            F3_LHU:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Requester <-> responder bus for data-memory accesses.
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Busy;
    logic        Done;
    logic        Fault;

    modport master (
        output MemRead, MemWrite, Funct3, Addr, WrData,
        input  RdData, Busy, Done, Fault
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, Addr, WrData,
        output RdData, Busy, Done, Fault
    );
endinterface

// File: rtl/dmem_bank.sv
// Four byte-lane RAMs sharing one word index; per-lane write enable and a
// registered read. Contents are never reset.
module dmem_bank #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    localparam int DEPTH = 2 ** IDX_W;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        // Lane write when enabled; registered read of the addressed byte.
        always_ff @(posedge clk) begin
            if (we && be[l]) begin
                mem_q[idx] <= wdata[8*l +: 8];
            end
            if (re) begin
                rd_q <= mem_q[idx];
            end
        end

        assign rdata[8*l +: 8] = rd_q;
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// pulses Done with extended load data or a fault.
//
// state | meaning
// IDLE  | sampling the bus; a request is latched here
// WAIT  | counting wait states before the memory access
// RESP  | one-cycle Done (and Fault/RdData) pulse
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int         IDX_W    = ADDR_W - 2;
    localparam bit         NO_WAIT  = (LATENCY == 0);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              fault_q, fault_d;

    logic              req;
    logic              req_fault;
    logic              in_idle;
    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        acc_f3;
    logic [31:0]       acc_wdata;
    logic              acc_wr;
    logic              acc_go;
    logic              bank_we;
    logic              bank_re;
    logic [31:0]       bank_rdata;
    logic              unused_addr_hi;

    assign req            = bus.MemRead | bus.MemWrite;
    assign req_fault      = access_fault(bus.Funct3, bus.Addr[1:0], bus.MemWrite);
    assign unused_addr_hi = ^bus.Addr[31:ADDR_W];
    assign in_idle        = (state_q == IDLE);

    // With zero wait states the access happens on the accepting edge, so the
    // bank must see the live bus instead of the not-yet-loaded latch.
    assign acc_addr  = in_idle ? bus.Addr[ADDR_W-1:0] : addr_q;
    assign acc_f3    = in_idle ? bus.Funct3 : f3_q;
    assign acc_wdata = in_idle ? bus.WrData : wdata_q;
    assign acc_wr    = in_idle ? bus.MemWrite : wr_q;
    assign acc_go    = (in_idle && req && !req_fault && NO_WAIT) ||
                       ((state_q == WAIT) && (cnt_q == 4'd0));

    // Gating with reset keeps a write from landing on an edge where reset holds.
    assign bank_we = acc_go && acc_wr && reset;
    assign bank_re = acc_go && !acc_wr;

    dmem_bank #(.IDX_W(IDX_W)) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .be    (store_be(acc_f3, acc_addr[1:0])),
        .re    (bank_re),
        .idx   (acc_addr[ADDR_W-1:2]),
        .wdata (store_data(acc_f3, acc_wdata)),
        .rdata (bank_rdata)
    );

    // State and request-latch registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic; faults skip the wait states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = (req_fault || NO_WAIT) ? RESP : WAIT;
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Wait counter and request latch; inputs are only sampled in IDLE.
    always_comb begin
        cnt_d   = 4'd0;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        fault_d = fault_q;
        if (in_idle && req) begin
            addr_d  = bus.Addr[ADDR_W-1:0];
            f3_d    = bus.Funct3;
            wdata_d = bus.WrData;
            wr_d    = bus.MemWrite;
            fault_d = req_fault;
            if (!req_fault && !NO_WAIT) cnt_d = CNT_LOAD;
        end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Outputs: Done/Fault/RdData from registered state only; Busy is combinational.
    always_comb begin
        bus.Done   = (state_q == RESP);
        bus.Fault  = (state_q == RESP) && fault_q;
        bus.RdData = 32'd0;
        if ((state_q == RESP) && !fault_q && !wr_q) begin
            bus.RdData = load_extend(bank_rdata, addr_q[1:0], f3_q);
        end
        bus.Busy = (state_q == WAIT) || (in_idle && req);
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none.
module tb_dmem_responder;
    import riscv_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dmem_responder_if bus2();
    dmem_responder_if bus0();

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel0, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel0) begin
            bus0.MemRead = rd; bus0.MemWrite = wr; bus0.Funct3 = f3;
            bus0.Addr = a; bus0.WrData = wd;
        end else begin
            bus2.MemRead = rd; bus2.MemWrite = wr; bus2.Funct3 = f3;
            bus2.Addr = a; bus2.WrData = wd;
        end
    endtask

    task automatic sample(input bit sel0, output logic b, output logic d, output logic f,
                          output logic [31:0] r);
        if (sel0) begin
            b = bus0.Busy; d = bus0.Done; f = bus0.Fault; r = bus0.RdData;
        end else begin
            b = bus2.Busy; d = bus2.Done; f = bus2.Fault; r = bus2.RdData;
        end
    endtask

    // One access: request raised mid-cycle 0, strobes held until Done.
    task automatic access(input bit sel0, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int cyc, output logic [31:0] rdat, output logic flt,
                          output logic [15:0] bmask, output logic done_after);
        logic b, d, f;
        logic [31:0] r;
        @(negedge clk);
        drive(sel0, rd, wr, f3, a, wd);
        #1;
        sample(sel0, b, d, f, r);
        bmask    = 16'h0;
        bmask[0] = b;
        cyc      = -1;
        rdat     = 32'hBADBAD00;
        flt      = 1'bx;
        for (int i = 1; i < 40; i++) begin
            @(posedge clk);
            #1;
            sample(sel0, b, d, f, r);
            if (i < 16) bmask[i] = b;
            if (d) begin
                cyc  = i;
                rdat = r;
                flt  = f;
                break;
            end
        end
        drive(sel0, 1'b0, 1'b0, f3, a, wd);
        @(posedge clk);
        #1;
        sample(sel0, b, d, f, r);
        done_after = d;
    endtask

    initial begin
        int          cyc;
        logic [31:0] rdat;
        logic        flt;
        logic [15:0] bm;
        logic        da;
        logic        b, d, f;
        logic [31:0] r;
        int          late_done;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #2;
        sample(1'b0, b, d, f, r);
        chk("rst_busy", 32'(b), 32'd0);
        chk("rst_done", 32'(d), 32'd0);
        chk("rst_fault", 32'(f), 32'd0);
        chk("rst_rddata", r, 32'd0);
        chk("rst_state", 32'(dut2.state_q), 32'(IDLE));
        sample(1'b1, b, d, f, r);
        chk("rst0_done", 32'(d), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Word store then load.
        access(1'b0, 1'b0, 1'b1, F3_LW, 32'h10, 32'hDEADBEEF, cyc, rdat, flt, bm, da);
        chk("sw_cycle", 32'(cyc), 32'd3);
        chk("sw_fault", 32'(flt), 32'd0);
        chk("sw_busy", 32'(bm), 32'h0007);
        access(1'b0, 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, cyc, rdat, flt, bm, da);
        chk("lw_cycle", 32'(cyc), 32'd3);
        chk("lw_data", rdat, 32'hDEADBEEF);
        chk("lw_fault", 32'(flt), 32'd0);
        chk("lw_busy", 32'(bm), 32'h0007);
        chk("lw_done_pulse", 32'(da), 32'd0);

        // Sub-word loads.
        access(1'b0, 1'b1, 1'b0, F3_LB, 32'h13, 32'h0, cyc, rdat, flt, bm, da);
        chk("lb_13", rdat, 32'hFFFFFFDE);
        access(1'b0, 1'b1, 1'b0, F3_LBU, 32'h13, 32'h0, cyc, rdat, flt, bm, da);
        chk("lbu_13", rdat, 32'h000000DE);
        access(1'b0, 1'b1, 1'b0, F3_LH, 32'h10, 32'h0, cyc, rdat, flt, bm, da);
        chk("lh_10", rdat, 32'hFFFFBEEF);
        access(1'b0, 1'b1, 1'b0, F3_LHU, 32'h12, 32'h0, cyc, rdat, flt, bm, da);
        chk("lhu_12", rdat, 32'h0000DEAD);
        chk("lhu_fault", 32'(flt), 32'd0);

        // Byte-lane store.
        access(1'b0, 1'b0, 1'b1, F3_LB, 32'h11, 32'h000000AA, cyc, rdat, flt, bm, da);
        chk("sb_fault", 32'(flt), 32'd0);
        access(1'b0, 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, cyc, rdat, flt, bm, da);
        chk("sb_lane1", rdat, 32'hDEADAAEF);

        // Faults.
        access(1'b0, 1'b1, 1'b0, F3_LW, 32'h12, 32'h0, cyc, rdat, flt, bm, da);
        chk("lw_mis_cycle", 32'(cyc), 32'd1);
        chk("lw_mis_fault", 32'(flt), 32'd1);
        chk("lw_mis_data", rdat, 32'd0);
        chk("lw_mis_busy", 32'(bm), 32'h0001);
        access(1'b0, 1'b0, 1'b1, F3_LH, 32'h11, 32'h0000FFFF, cyc, rdat, flt, bm, da);
        chk("sh_mis_cycle", 32'(cyc), 32'd1);
        chk("sh_mis_fault", 32'(flt), 32'd1);
        access(1'b0, 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, cyc, rdat, flt, bm, da);
        chk("sh_mis_nowrite", rdat, 32'hDEADAAEF);
        access(1'b0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, cyc, rdat, flt, bm, da);
        chk("f3_011_fault", 32'(flt), 32'd1);
        chk("f3_011_data", rdat, 32'd0);
        access(1'b0, 1'b0, 1'b1, F3_LBU, 32'h10, 32'h11223344, cyc, rdat, flt, bm, da);
        chk("sbu_fault", 32'(flt), 32'd1);
        access(1'b0, 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, cyc, rdat, flt, bm, da);
        chk("sbu_nowrite", rdat, 32'hDEADAAEF);

        // Reset during WAIT aborts the store.
        access(1'b0, 1'b0, 1'b1, F3_LW, 32'h20, 32'hCAFEF00D, cyc, rdat, flt, bm, da);
        chk("sw20_cycle", 32'(cyc), 32'd3);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, F3_LW, 32'h20, 32'h12345678);
        @(posedge clk);
        #1;
        chk("mid_state_wait", 32'(dut2.state_q), 32'(WAIT));
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, F3_LW, 32'h20, 32'h12345678);
        #1;
        sample(1'b0, b, d, f, r);
        chk("mid_rst_busy", 32'(b), 32'd0);
        chk("mid_rst_done", 32'(d), 32'd0);
        chk("mid_rst_fault", 32'(f), 32'd0);
        chk("mid_rst_rddata", r, 32'd0);
        chk("mid_rst_state", 32'(dut2.state_q), 32'(IDLE));
        chk("mid_rst_cnt", 32'(dut2.cnt_q), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        late_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus2.Done) late_done++;
        end
        chk("mid_rst_no_done", 32'(late_done), 32'd0);
        access(1'b0, 1'b1, 1'b0, F3_LW, 32'h20, 32'h0, cyc, rdat, flt, bm, da);
        chk("mid_rst_nowrite", rdat, 32'hCAFEF00D);

        // Zero wait states, both strobes high: treated as a store.
        access(1'b1, 1'b1, 1'b1, F3_LW, 32'h40, 32'h5A5AA5A5, cyc, rdat, flt, bm, da);
        chk("l0_both_cycle", 32'(cyc), 32'd1);
        chk("l0_both_fault", 32'(flt), 32'd0);
        chk("l0_both_rddata", rdat, 32'd0);
        chk("l0_both_busy", 32'(bm), 32'h0001);
        access(1'b1, 1'b1, 1'b0, F3_LW, 32'h40, 32'h0, cyc, rdat, flt, bm, da);
        chk("l0_lw_cycle", 32'(cyc), 32'd1);
        chk("l0_lw_data", rdat, 32'h5A5AA5A5);
        access(1'b1, 1'b1, 1'b0, F3_LH, 32'h41, 32'h0, cyc, rdat, flt, bm, da);
        chk("l0_fault_cycle", 32'(cyc), 32'd1);
        chk("l0_fault", 32'(flt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
